kg_patch_sched: RTL and testbench

- Per-port scheduler that sequences the kugelblitz byte-patch datapath on a 512-bit Ethernet AXI stream.
- Holds the patch rule (enable, byte offset within frame, value) in a pending/active shadow pair fed by the AXI-lite regfile. The rule is committed only at frame boundaries, so a frame is never patched with a half-updated rule.
- Tracks beat position inside each frame and drives a one-hot byte-lane select plus the patch value to the datapath mux, aligned to the current beat.
- Sits between the per-port regfile outputs and the tx/rx offload datapath; one instance per direction per port.

---
 rtl/kg_patch_sched.sv | 172 +++++++++++++++++
 tb/tb_kg_patch_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kg_patch_sched.sv
// kg_patch_sched -- per-port byte-patch scheduler for a 512-bit AXI stream.
//
// This block monitors the stream and tells the datapath mux which byte lane
// of the current beat to overwrite, and with what value. It never stalls the
// stream.
//
// The patch rule {enable, byte offset, value} arrives from the regfile into a
// pending copy. It is promoted to the active copy only at a frame boundary,
// so a frame never sees a half-updated rule.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cfg_wr              one-cycle strobe that captures cfg_enable/offset/value
//   mon_t*              monitored stream handshake, tlast and tkeep
//   patch_sel           one-hot lane to replace in the current beat (combinational)
//   patch_value         replacement byte from the active rule
//   cfg_pending         a written rule is waiting for commit
//   active_enable       enable bit of the active rule
//   in_frame            FSM is inside a multi-beat frame
//
// Optional statistics (enabled when KG_PATCH_SCHED_STATS_EN is defined):
//   stat_clr            synchronous clear; wins over a same-cycle increment
//   stat_patched        frames that had a lane patched
//   stat_missed         frames that ended with an enabled rule but no hit
module kg_patch_sched #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int OFFSET_WIDTH = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic                    cfg_enable,
  input  logic [OFFSET_WIDTH-1:0] cfg_offset,
  input  logic [7:0]              cfg_value,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  input  logic [KEEP_WIDTH-1:0]   mon_tkeep,
`ifdef KG_PATCH_SCHED_STATS_EN
  input  logic                    stat_clr,
  output logic [CNT_WIDTH-1:0]    stat_patched,
  output logic [CNT_WIDTH-1:0]    stat_missed,
`endif
  output logic [KEEP_WIDTH-1:0]   patch_sel,
  output logic [7:0]              patch_value,
  output logic                    cfg_pending,
  output logic                    active_enable,
  output logic                    in_frame
);

  localparam int LANE_W = 6;
  localparam int BEAT_W = OFFSET_WIDTH - LANE_W;

  if (DATA_WIDTH != 512) begin : g_bad_data_width
    $error("kg_patch_sched: DATA_WIDTH must be 512");
  end
  if (KEEP_WIDTH*8 != DATA_WIDTH) begin : g_bad_keep_width
    $error("kg_patch_sched: KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (OFFSET_WIDTH <= LANE_W) begin : g_bad_offset_width
    $error("kg_patch_sched: OFFSET_WIDTH must exceed the lane bits");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("kg_patch_sched: CNT_WIDTH must be positive");
  end

  typedef struct packed {
    logic                    en;
    logic [OFFSET_WIDTH-1:0] off;
    logic [7:0]              val;
  } rule_t;

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t            state, state_nx;
  rule_t             pend, act, wr_rule, commit_rule;
  logic [BEAT_W-1:0] beat_cnt;
  logic              beat_ovf;   // frame ran past the last countable beat
  logic              acc, acc_last, commit, beat_hit;

  assign acc      = mon_tvalid & mon_tready;
  assign acc_last = acc & mon_tlast;

  // A write in the commit cycle counts as pending and its values win.
  assign wr_rule     = '{en: cfg_enable, off: cfg_offset, val: cfg_value};
  assign commit_rule = cfg_wr ? wr_rule : pend;
  assign commit      = (cfg_pending | cfg_wr) &
                       (((state == IDLE) & ~acc) | acc_last);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (acc) state_nx = mon_tlast ? IDLE : FRAME;
  end

  // FSM: outputs
  always_comb begin
    in_frame = (state == FRAME);
  end

  // Rule shadow pair and beat tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      act         <= '0;
      cfg_pending <= 1'b0;
      beat_cnt    <= '0;
      beat_ovf    <= 1'b0;
    end else begin
      if (cfg_wr) pend <= wr_rule;
      if (commit) act  <= commit_rule;
      if (commit)      cfg_pending <= 1'b0;
      else if (cfg_wr) cfg_pending <= 1'b1;

      if (acc_last) begin
        beat_cnt <= '0;
        beat_ovf <= 1'b0;
      end else if (acc) begin
        // Counter holds at all-ones; the overflow bit stops the last
        // countable beat index from matching every later beat.
        if (&beat_cnt) beat_ovf <= 1'b1;
        else           beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Beat-level qualifier shared by every lane
  assign beat_hit = act.en & mon_tvalid & ~beat_ovf &
                    (beat_cnt == act.off[OFFSET_WIDTH-1:LANE_W]);

  for (genvar l = 0; l < KEEP_WIDTH; l++) begin : g_lane
    assign patch_sel[l] = beat_hit & mon_tkeep[l] &
                          (act.off[LANE_W-1:0] == LANE_W'(l));
  end

  assign patch_value   = act.val;
  assign active_enable = act.en;

`ifdef KG_PATCH_SCHED_STATS_EN
  logic hit;        // a lane was patched earlier in this frame
  logic frame_hit;  // includes a hit on the current (tlast) beat

  assign frame_hit = hit | (|patch_sel);

  always_ff @(posedge clk) begin
    if (rst)                    hit <= 1'b0;
    else if (acc_last)          hit <= 1'b0;
    else if (acc && |patch_sel) hit <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_patched <= '0;
      stat_missed  <= '0;
    end else if (acc_last) begin
      if (frame_hit && !(&stat_patched))
        stat_patched <= stat_patched + 1'b1;
      if (act.en && !frame_hit && !(&stat_missed))
        stat_missed <= stat_missed + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kg_patch_sched.sv
// Directed bench for kg_patch_sched. Each task drives one scenario and checks
// outputs against hand-computed values. Stats checks apply only when
// KG_PATCH_SCHED_STATS_EN is defined.
module tb_kg_patch_sched;
  localparam int KW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr, cfg_enable;
  logic [15:0]   cfg_offset;
  logic [7:0]    cfg_value;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic [KW-1:0] mon_tkeep;
  logic [KW-1:0] patch_sel;
  logic [7:0]    patch_value;
  logic          cfg_pending, active_enable, in_frame;
  logic          stat_clr;
  logic [CW-1:0] stat_patched, stat_missed;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_patched = 0;
  int exp_missed  = 0;
  logic [KW-1:0] exp_sel;

  always #5 clk = ~clk;

  kg_patch_sched dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_enable   (cfg_enable),
    .cfg_offset   (cfg_offset),
    .cfg_value    (cfg_value),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .mon_tkeep    (mon_tkeep),
`ifdef KG_PATCH_SCHED_STATS_EN
    .stat_clr     (stat_clr),
    .stat_patched (stat_patched),
    .stat_missed  (stat_missed),
`endif
    .patch_sel    (patch_sel),
    .patch_value  (patch_value),
    .cfg_pending  (cfg_pending),
    .active_enable(active_enable),
    .in_frame     (in_frame)
  );

`ifndef KG_PATCH_SCHED_STATS_EN
  assign stat_patched = '0;
  assign stat_missed  = '0;
`endif

  // Stimulus helpers (drive only)
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b0; mon_tkeep = '1;
    cfg_wr = 1'b0;
  endtask

  task automatic drive(input logic v, input logic r, input logic l, input logic [KW-1:0] k);
    mon_tvalid = v; mon_tready = r; mon_tlast = l; mon_tkeep = k;
    #1;
  endtask

  task automatic set_cfg(input logic en, input logic [15:0] off, input logic [7:0] val);
    cfg_wr = 1'b1; cfg_enable = en; cfg_offset = off; cfg_value = val;
  endtask

  // Write while idle with no beat: commits at this edge.
  task automatic write_rule(input logic en, input logic [15:0] off, input logic [7:0] val);
    idle();
    set_cfg(en, off, val);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    idle(); stat_clr = 1'b0; cfg_enable = 0; cfg_offset = 0; cfg_value = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (patch_sel !== '0)   begin n_fail++; $display("FAIL reset_sel got %h exp 0", patch_sel); end
    n_chk++; if (patch_value !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h exp 00", patch_value); end
    n_chk++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", cfg_pending); end
    n_chk++; if (active_enable !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0", active_enable); end
    n_chk++; if (in_frame !== 1'b0)  begin n_fail++; $display("FAIL reset_in_frame got %b exp 0", in_frame); end
  endtask

  task automatic test_stats(input string tag);
`ifdef KG_PATCH_SCHED_STATS_EN
    n_chk++; if (stat_patched !== CW'(exp_patched)) begin n_fail++; $display("FAIL %s stat_patched got %0d exp %0d", tag, stat_patched, exp_patched); end
    n_chk++; if (stat_missed !== CW'(exp_missed)) begin n_fail++; $display("FAIL %s stat_missed got %0d exp %0d", tag, stat_missed, exp_missed); end
`endif
  endtask

  // offset 70 = beat 1 lane 6
  task automatic test_basic();
    write_rule(1'b1, 16'd70, 8'h5A);
    n_chk++; if (active_enable !== 1'b1) begin n_fail++; $display("FAIL basic_active got %b exp 1", active_enable); end
    n_chk++; if (patch_value !== 8'h5A) begin n_fail++; $display("FAIL basic_value got %h exp 5a", patch_value); end
    n_chk++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending got %b exp 0", cfg_pending); end
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 1'b1, b == 2, '1);
      exp_sel = '0; if (b == 1) exp_sel[6] = 1'b1;
      n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL basic_sel beat%0d got %h exp %h", b, patch_sel, exp_sel); end
      tick();
      if (b == 0) begin
        n_chk++; if (in_frame !== 1'b1) begin n_fail++; $display("FAIL basic_in_frame got %b exp 1", in_frame); end
      end
    end
    idle();
    n_chk++; if (in_frame !== 1'b0) begin n_fail++; $display("FAIL basic_frame_end got %b exp 0", in_frame); end
    exp_patched++;
    test_stats("basic");
  endtask

  // active offset 130 = beat 2 lane 2; new rule offset 3 written mid-frame
  task automatic test_midframe_update();
    write_rule(1'b1, 16'd130, 8'h77);
    drive(1'b1, 1'b1, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL mid_sel beat0 got %h exp 0", patch_sel); end
    tick();
    set_cfg(1'b1, 16'd3, 8'h33);
    drive(1'b1, 1'b1, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL mid_sel beat1 got %h exp 0", patch_sel); end
    tick();
    cfg_wr = 1'b0;
    n_chk++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending got %b exp 1", cfg_pending); end
    n_chk++; if (patch_value !== 8'h77) begin n_fail++; $display("FAIL mid_value_held got %h exp 77", patch_value); end
    drive(1'b1, 1'b1, 1'b0, '1);
    exp_sel = '0; exp_sel[2] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL mid_sel beat2 got %h exp %h", patch_sel, exp_sel); end
    tick();
    n_chk++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending2 got %b exp 1", cfg_pending); end
    drive(1'b1, 1'b1, 1'b1, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL mid_sel beat3 got %h exp 0", patch_sel); end
    tick();
    idle();
    n_chk++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL mid_commit_pending got %b exp 0", cfg_pending); end
    n_chk++; if (patch_value !== 8'h33) begin n_fail++; $display("FAIL mid_commit_value got %h exp 33", patch_value); end
    exp_patched++;
    drive(1'b1, 1'b1, 1'b0, '1);
    exp_sel = '0; exp_sel[3] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL mid_next_sel beat0 got %h exp %h", patch_sel, exp_sel); end
    tick();
    drive(1'b1, 1'b1, 1'b1, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL mid_next_sel beat1 got %h exp 0", patch_sel); end
    tick();
    idle();
    exp_patched++;
    test_stats("mid");
  endtask

  // rule write lands on the tlast beat; offset 65 = beat 1 lane 1
  task automatic test_wr_on_tlast();
    drive(1'b1, 1'b1, 1'b0, '1);
    exp_sel = '0; exp_sel[3] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL wrlast_sel beat0 got %h exp %h", patch_sel, exp_sel); end
    tick();
    set_cfg(1'b1, 16'd65, 8'hC3);
    drive(1'b1, 1'b1, 1'b1, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL wrlast_sel beat1 got %h exp 0", patch_sel); end
    tick();
    idle();
    n_chk++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL wrlast_pending got %b exp 0", cfg_pending); end
    n_chk++; if (patch_value !== 8'hC3) begin n_fail++; $display("FAIL wrlast_value got %h exp c3", patch_value); end
    exp_patched++;
    drive(1'b1, 1'b1, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL wrlast_next beat0 got %h exp 0", patch_sel); end
    tick();
    drive(1'b1, 1'b1, 1'b1, '1);
    exp_sel = '0; exp_sel[1] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL wrlast_next beat1 got %h exp %h", patch_sel, exp_sel); end
    tick();
    idle();
    exp_patched++;
    test_stats("wrlast");
  endtask

  task automatic test_miss();
    // offset 200 = beat 3 lane 8, beyond a 2-beat frame
    write_rule(1'b1, 16'd200, 8'h11);
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 1'b1, b == 1, '1);
      n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL miss_far beat%0d got %h exp 0", b, patch_sel); end
      tick();
    end
    exp_missed++;
    test_stats("miss_far");
    // offset 60 = beat 0 lane 60, but that lane has tkeep cleared
    write_rule(1'b1, 16'd60, 8'h22);
    drive(1'b1, 1'b1, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL miss_keep beat0 got %h exp 0", patch_sel); end
    tick();
    drive(1'b1, 1'b1, 1'b1, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL miss_keep beat1 got %h exp 0", patch_sel); end
    tick();
    idle();
    exp_missed++;
    test_stats("miss_keep");
  endtask

  task automatic test_single_beat();
    write_rule(1'b1, 16'd0, 8'h99);
    exp_sel = '0; exp_sel[0] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, 1'b1, 1'b1, '1);
      n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL single_sel frame%0d got %h exp %h", f, patch_sel, exp_sel); end
      tick();
      n_chk++; if (in_frame !== 1'b0) begin n_fail++; $display("FAIL single_in_frame frame%0d got %b exp 0", f, in_frame); end
      exp_patched++;
    end
    idle();
    test_stats("single");
  endtask

  // offset 65 = beat 1 lane 1; stalled and invalid beats must not advance
  task automatic test_stall();
    write_rule(1'b1, 16'd65, 8'h5C);
    drive(1'b1, 1'b0, 1'b0, '1); tick();
    drive(1'b1, 1'b0, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL stall_sel_hold got %h exp 0", patch_sel); end
    tick();
    drive(1'b1, 1'b1, 1'b0, '1); tick();
    drive(1'b0, 1'b1, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL stall_sel_novalid got %h exp 0", patch_sel); end
    tick();
    drive(1'b1, 1'b1, 1'b1, '1);
    exp_sel = '0; exp_sel[1] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL stall_sel beat1 got %h exp %h", patch_sel, exp_sel); end
    tick();
    idle();
    exp_patched++;
    test_stats("stall");
  endtask

  // reset during beat 2 of a 5-beat frame; offset 130 = beat 2 lane 2
  task automatic test_rst_midframe();
    write_rule(1'b1, 16'd130, 8'h44);
    drive(1'b1, 1'b1, 1'b0, '1); tick();
    drive(1'b1, 1'b1, 1'b0, '1); tick();
    drive(1'b1, 1'b1, 1'b0, '1);
    exp_sel = '0; exp_sel[2] = 1'b1;
    n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL rst_pre_sel got %h exp %h", patch_sel, exp_sel); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_patched = 0; exp_missed = 0;
    n_chk++; if (patch_value !== 8'h00) begin n_fail++; $display("FAIL rst_value got %h exp 00", patch_value); end
    n_chk++; if (active_enable !== 1'b0) begin n_fail++; $display("FAIL rst_active got %b exp 0", active_enable); end
    n_chk++; if (in_frame !== 1'b0) begin n_fail++; $display("FAIL rst_in_frame got %b exp 0", in_frame); end
    n_chk++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %b exp 0", cfg_pending); end
    test_stats("rst");
    drive(1'b1, 1'b1, 1'b0, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL rst_beat3_sel got %h exp 0", patch_sel); end
    tick();
    n_chk++; if (in_frame !== 1'b1) begin n_fail++; $display("FAIL rst_restart_frame got %b exp 1", in_frame); end
    drive(1'b1, 1'b1, 1'b1, '1);
    n_chk++; if (patch_sel !== '0) begin n_fail++; $display("FAIL rst_beat4_sel got %h exp 0", patch_sel); end
    tick();
    write_rule(1'b1, 16'd130, 8'h44);
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 1'b1, b == 2, '1);
      exp_sel = '0; if (b == 2) exp_sel[2] = 1'b1;
      n_chk++; if (patch_sel !== exp_sel) begin n_fail++; $display("FAIL rst_after beat%0d got %h exp %h", b, patch_sel, exp_sel); end
      tick();
    end
    idle();
    exp_patched++;
    test_stats("rst_after");
  endtask

  // clear wins over a same-cycle missed-frame increment (offset 130, 1-beat frame)
  task automatic test_stat_clr();
`ifdef KG_PATCH_SCHED_STATS_EN
    stat_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b1, '1);
    tick();
    stat_clr = 1'b0;
    idle();
    exp_patched = 0; exp_missed = 0;
    test_stats("clr");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_update();
    test_wr_on_tlast();
    test_miss();
    test_single_beat();
    test_stall();
    test_rst_midframe();
    test_stat_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
